// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared core types and instruction buffer defaults
package core_pkg;

    localparam int INSN_W   = 16;
    localparam int IB_DEPTH = 8;
    localparam int IB_SKID  = 2;

    typedef logic [INSN_W-1:0] insn_t;

endpackage

// File: rtl/inst_buffer_if.sv
// rtl/inst_buffer_if.sv - fetch/decode side signals of the instruction buffer
//
// Ports (all members of the interface):
//   ib_push, ib_push_data  push request and word from fetch
//   ib_full                back-pressure to fetch (asserts SKID slots early)
//   ib_pop                 decoder consumes head entry
//   ib_empty, ib_pop_data  head-valid flag and head word
//   ib_count               current occupancy
//   flush                  taken branch, discard all entries
//   overflow               sticky: push arrived while completely full
// Modport master is the fetch/decode side, slave is the buffer.
interface inst_buffer_if
    import core_pkg::*;
#(
    parameter int DEPTH = IB_DEPTH
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic          ib_push;
    insn_t         ib_push_data;
    logic          ib_full;
    logic          ib_pop;
    logic          ib_empty;
    insn_t         ib_pop_data;
    logic [CW-1:0] ib_count;
    logic          flush;
    logic          overflow;

    modport master (
        output ib_push, ib_push_data, ib_pop, flush,
        input  ib_full, ib_empty, ib_pop_data, ib_count, overflow
    );

    modport slave (
        input  ib_push, ib_push_data, ib_pop, flush,
        output ib_full, ib_empty, ib_pop_data, ib_count, overflow
    );

endinterface

// File: rtl/ib_storage.sv
// rtl/ib_storage.sv - instruction word array, one sync write port, one comb read port
//
// Ports:
//   clk           write clock
//   we            write enable
//   waddr, wdata  write address and word
//   raddr, rdata  combinational read address and word
// Contents are intentionally not reset.
module ib_storage
    import core_pkg::*;
#(
    parameter int DEPTH = IB_DEPTH,
    localparam int PW   = $clog2(DEPTH)
)(
    input  logic          clk,
    input  logic          we,
    input  logic [PW-1:0] waddr,
    input  insn_t         wdata,
    input  logic [PW-1:0] raddr,
    output insn_t         rdata
);

    insn_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/inst_buffer.sv
// rtl/inst_buffer.sv - first-word-fall-through instruction FIFO between fetch and decode
//
// Ports:
//   clk    single clock, all state on posedge
//   reset  asynchronous active-high, clears pointers, count and overflow
//   ib     inst_buffer_if.slave bundle (push/pop/flush in, status and head word out)
// ib_full asserts at DEPTH-SKID entries so fetch responses already in flight
// still land in the reserved slots.
module inst_buffer
    import core_pkg::*;
#(
    parameter int DEPTH = IB_DEPTH,
    parameter int SKID  = IB_SKID
)(
    input  logic          clk,
    input  logic          reset,
    inst_buffer_if.slave  ib
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [CW-1:0] FULL_AT_C = CW'(DEPTH - SKID);

    logic [PW-1:0] rp;
    logic [PW-1:0] wp;
    logic [CW-1:0] count;
    logic          overflow_q;

    logic at_depth;
    logic is_empty;
    logic pop_ok;
    logic push_ok;
    logic drop;

    assign at_depth = (count == DEPTH_C);
    assign is_empty = (count == '0);

    // Flush wins over everything in the same cycle.
    assign pop_ok  = ib.ib_pop && !is_empty && !ib.flush;
    // A push at full depth is still accepted when a pop frees the head slot.
    assign push_ok = ib.ib_push && !ib.flush && (!at_depth || pop_ok);
    assign drop    = ib.ib_push && !ib.flush && at_depth && !pop_ok;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rp         <= '0;
            wp         <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (ib.flush) begin
                rp    <= '0;
                wp    <= '0;
                count <= '0;
            end else begin
                if (push_ok) begin
                    wp <= wp + PW'(1);
                end
                if (pop_ok) begin
                    rp <= rp + PW'(1);
                end
                if (push_ok && !pop_ok) begin
                    count <= count + CW'(1);
                end else if (pop_ok && !push_ok) begin
                    count <= count - CW'(1);
                end
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    ib_storage #(
        .DEPTH (DEPTH)
    ) u_storage (
        .clk   (clk),
        .we    (push_ok),
        .waddr (wp),
        .wdata (ib.ib_push_data),
        .raddr (rp),
        .rdata (ib.ib_pop_data)
    );

    assign ib.ib_full  = (count >= FULL_AT_C);
    assign ib.ib_empty = is_empty;
    assign ib.ib_count = count;
    assign ib.overflow = overflow_q;

endmodule

// File: tb/tb_inst_buffer.sv
// tb/tb_inst_buffer.sv - directed table-driven bench for inst_buffer
module tb_inst_buffer;
    import core_pkg::*;

    localparam int DEPTH = 8;
    localparam int SKID  = 2;

    typedef struct {
        logic        push;
        logic [15:0] data;
        logic        pop;
        logic        flush;
        int          count;
        logic        empty;
        logic        full;
        logic        ovf;
        logic        chk_head;
        logic [15:0] head;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    vec_t vecs[$];

    inst_buffer_if #(.DEPTH(DEPTH)) ibus ();

    inst_buffer #(
        .DEPTH (DEPTH),
        .SKID  (SKID)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .ib    (ibus.slave)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic push, logic [15:0] data, logic pop, logic flush,
                                int count, logic ovf, logic chk_head, logic [15:0] head);
        vec_t v;
        v.push     = push;
        v.data     = data;
        v.pop      = pop;
        v.flush    = flush;
        v.count    = count;
        v.empty    = (count == 0);
        v.full     = (count >= DEPTH - SKID);
        v.ovf      = ovf;
        v.chk_head = chk_head;
        v.head     = head;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_status(string tag, int count, logic ovf);
        check({tag, " count"}, 32'(ibus.ib_count), 32'(count));
        check({tag, " empty"}, 32'(ibus.ib_empty), 32'(count == 0));
        check({tag, " full"}, 32'(ibus.ib_full), 32'(count >= DEPTH - SKID));
        check({tag, " overflow"}, 32'(ibus.overflow), 32'(ovf));
    endtask

    task automatic apply(vec_t v, int idx);
        ibus.ib_push      = v.push;
        ibus.ib_push_data = v.data;
        ibus.ib_pop       = v.pop;
        ibus.flush        = v.flush;
        @(posedge clk);
        #1;
        ibus.ib_push = 1'b0;
        ibus.ib_pop  = 1'b0;
        ibus.flush   = 1'b0;
        check($sformatf("vec%0d count", idx), 32'(ibus.ib_count), 32'(v.count));
        check($sformatf("vec%0d empty", idx), 32'(ibus.ib_empty), 32'(v.empty));
        check($sformatf("vec%0d full", idx), 32'(ibus.ib_full), 32'(v.full));
        check($sformatf("vec%0d overflow", idx), 32'(ibus.overflow), 32'(v.ovf));
        if (v.chk_head) begin
            check($sformatf("vec%0d head", idx), 32'(ibus.ib_pop_data), 32'(v.head));
        end
    endtask

    initial begin
        ibus.ib_push      = 1'b0;
        ibus.ib_push_data = '0;
        ibus.ib_pop       = 1'b0;
        ibus.flush        = 1'b0;

        // In-order push then drain, pop while empty, push into empty with pop held.
        vecs.push_back(mk(1, 16'h1111, 0, 0, 1, 0, 1, 16'h1111));
        vecs.push_back(mk(1, 16'h2222, 0, 0, 2, 0, 1, 16'h1111));
        vecs.push_back(mk(1, 16'h3333, 0, 0, 3, 0, 1, 16'h1111));
        vecs.push_back(mk(0, 16'h0000, 1, 0, 2, 0, 1, 16'h2222));
        vecs.push_back(mk(0, 16'h0000, 1, 0, 1, 0, 1, 16'h3333));
        vecs.push_back(mk(0, 16'h0000, 1, 0, 0, 0, 0, 16'h0000));
        vecs.push_back(mk(0, 16'h0000, 1, 0, 0, 0, 0, 16'h0000));
        vecs.push_back(mk(1, 16'h0001, 1, 0, 1, 0, 1, 16'h0001));
        vecs.push_back(mk(0, 16'h0000, 1, 0, 0, 0, 0, 16'h0000));
        // Fill to DEPTH; ib_full rises at DEPTH-SKID.
        for (int i = 0; i < DEPTH; i++)
            vecs.push_back(mk(1, 16'h1000 + 16'(i), 0, 0, i + 1, 0, 1, 16'h1000));
        // Push+pop at full depth for 10 cycles, across pointer wrap.
        for (int k = 1; k <= 10; k++)
            vecs.push_back(mk(1, 16'hA000 + 16'(k - 1), 1, 0, DEPTH, 0, 1,
                              (k < 8) ? 16'h1000 + 16'(k) : 16'hA000 + 16'(k - 8)));
        // Push at full depth without a pop is dropped.
        vecs.push_back(mk(1, 16'hDEAD, 0, 0, 8, 1, 1, 16'hA002));
        // Drain to 5 across the ib_full threshold.
        vecs.push_back(mk(0, 16'h0000, 1, 0, 7, 1, 1, 16'hA003));
        vecs.push_back(mk(0, 16'h0000, 1, 0, 6, 1, 1, 16'hA004));
        vecs.push_back(mk(0, 16'h0000, 1, 0, 5, 1, 1, 16'hA005));
        // Flush with concurrent push and pop; overflow survives.
        vecs.push_back(mk(1, 16'hBEEF, 1, 1, 0, 1, 0, 16'h0000));
        vecs.push_back(mk(1, 16'hC0DE, 0, 0, 1, 1, 1, 16'hC0DE));
        vecs.push_back(mk(1, 16'h0D01, 0, 0, 2, 1, 1, 16'hC0DE));
        vecs.push_back(mk(1, 16'h0D02, 0, 0, 3, 1, 1, 16'hC0DE));
        vecs.push_back(mk(1, 16'h0D03, 0, 0, 4, 1, 1, 16'hC0DE));

        repeat (2) @(posedge clk);
        #1;
        check_status("reset", 0, 0);
        #3 reset = 1'b0;

        foreach (vecs[i]) apply(vecs[i], i);

        // Asynchronous reset between edges with count 4 and overflow set.
        #3 reset = 1'b1;
        #1;
        check_status("async_reset", 0, 0);
        #2 reset = 1'b0;

        // Buffer works again after reset.
        apply(mk(1, 16'h5555, 0, 0, 1, 0, 1, 16'h5555), 99);
        apply(mk(0, 16'h0000, 1, 0, 0, 0, 0, 16'h0000), 100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
